// File: rtl/rr_reg_write_arbiter_pkg.sv
// Shared definitions for the round-robin register write arbiter.
// The FSM alternates between arbitration (IDLE) and a one-cycle write slot (GRANT).
package rr_reg_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_reg_write_arbiter_register_en.sv
// W-bit enable register: a bank of D flops sharing clock and enable.
// Cleared asynchronously by reset_n.
module rr_reg_write_arbiter_register_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Storage: load d only on cycles where en is asserted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= {W{1'b0}};
    end else if (en) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin write arbiter for one shared W-bit register.
// One requester is granted per IDLE->GRANT pass; its data is written when still requesting.
module rr_reg_write_arbiter
  import rr_reg_write_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic           we,
  output logic [W-1:0]   q,
  output logic [IW-1:0]  last_id,
  output logic           busy
);

  arb_state_e    state_r, state_nxt_s;
  logic [IW-1:0] ptr_r, ptr_nxt_s;
  logic [IW-1:0] sel_r, sel_nxt_s;
  logic [N-1:0]  gnt_r, gnt_nxt_s;
  logic [IW-1:0] last_id_r, last_id_nxt_s;
  logic [IW-1:0] pick_s;
  logic          found_s;
  logic [IW:0]   idx_sum_s;
  logic [IW-1:0] idx_s;
  logic [W-1:0]  wd_sel_s;
  logic          we_s;

  // Priority search starting at ptr, wrapping modulo N
  always_comb begin
    pick_s    = {IW{1'b0}};
    found_s   = 1'b0;
    idx_sum_s = {(IW+1){1'b0}};
    idx_s     = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx_sum_s = {1'b0, ptr_r} + (IW+1)'(k);
      if (idx_sum_s >= (IW+1)'(N)) begin
        idx_sum_s = idx_sum_s - (IW+1)'(N);
      end else begin
        idx_sum_s = idx_sum_s;
      end
      idx_s = idx_sum_s[IW-1:0];
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Data mux selecting the granted requester's lane
  always_comb begin
    wd_sel_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (sel_r == IW'(i)) begin
        wd_sel_s = wdata[i*W +: W];
      end else begin
        wd_sel_s = wd_sel_s;
      end
    end
  end

  // A grant whose request was withdrawn produces no write
  assign we_s = (state_r == ST_GRANT) ? req[sel_r] : 1'b0;

  // Next-state logic for FSM, pointer, grant and last writer
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    sel_nxt_s     = sel_r;
    gnt_nxt_s     = {N{1'b0}};
    last_id_nxt_s = last_id_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s       = ST_GRANT;
          sel_nxt_s         = pick_s;
          gnt_nxt_s[pick_s] = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (we_s) begin
          last_id_nxt_s = sel_r;
        end else begin
          last_id_nxt_s = last_id_r;
        end
        if (sel_r == IW'(N-1)) begin
          ptr_nxt_s = {IW{1'b0}};
        end else begin
          ptr_nxt_s = sel_r + IW'(1);
        end
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM and arbitration state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {IW{1'b0}};
      sel_r     <= {IW{1'b0}};
      gnt_r     <= {N{1'b0}};
      last_id_r <= {IW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      sel_r     <= sel_nxt_s;
      gnt_r     <= gnt_nxt_s;
      last_id_r <= last_id_nxt_s;
    end
  end

  rr_reg_write_arbiter_register_en #(.W(W)) u_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (we_s),
    .d       (wd_sel_s),
    .q       (q)
  );

  assign gnt     = gnt_r;
  assign we      = we_s;
  assign last_id = last_id_r;
  assign busy    = (state_r == ST_GRANT);

endmodule
